instr_register_alu: RTL and testbench
=====================================

Name: instr_register_alu

Overview:
- Parametrised successor of the 32-entry instruction register.
- Each accepted write passes through a 2-stage ALU pipeline that computes the result from opcode/operand_a/operand_b.
- The stored entry holds {opcode, operand_a, operand_b, result, div_err}, plus a per-entry valid bit.
- Sits between the instruction source (testbench/sequencer) and the readback/scoreboard path. Adds read validity, a bulk clear, and an occupancy counter.

Parameters:
- OP_W, 32, signed operand width.
- DEPTH, 32, number of entries (power of two, >=2).
- AW, $clog2(DEPTH), pointer width; derived, never overridden.
- RES_W, 2*OP_W, result width; derived.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_en  in  1  write request; sampled every edge, no back-pressure.
- clear_en  in  1  invalidates all entries.
- operand_a  in  OP_W  signed operand A.
- operand_b  in  OP_W  signed operand B.
- opcode  in  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- write_pointer  in  AW  target entry.
- read_pointer  in  AW  entry to read; sampled every edge.
- rd_opcode  out  3  stored opcode.
- rd_op_a  out  OP_W  stored operand A.
- rd_op_b  out  OP_W  stored operand B.
- rd_result  out  RES_W  stored signed result.
- rd_valid  out  1  entry has been written since reset/clear.
- rd_div_err  out  1  stored DIV/MOD had operand_b == 0.
- entry_count  out  AW+1  number of valid entries, 0..DEPTH.
- pipe_busy  out  1  at least one write is in flight (stage 1 or stage 2).

Behaviour:
- Reset (reset_n == 0 at edge) clears:
  - all outputs to 0;
  - all valid bits;
  - both pipeline stages (in-flight writes are discarded);
  - entry_count.
- Reset dominates every other input. Memory data contents need not be cleared.
- Stage 1 (edge E with load_en = 1): register opcode, operand_a, operand_b, write_pointer; set s1_vld.
- Stage 2 (edge E+1): compute result from the stage-1 registers and commit the entry at the stored pointer. Set valid; pipe_busy drops at E+2 if no new write follows.
- Back-to-back writes accepted every cycle. Throughput is 1 per cycle; write latency is 2 edges.
- Arithmetic, operands signed:
  - ZERO -> 0.
  - PASSA/PASSB -> sign-extended operand.
  - ADD/SUB -> sign-extended to RES_W, no overflow loss.
  - MULT -> full RES_W product.
  - DIV -> truncating quotient, sign-extended.
  - MOD -> remainder with sign of operand_a.
- DIV/MOD with operand_b == 0: result = 0, div_err = 1. All other cases: div_err = 0.
- Read: read_pointer sampled at edge R; rd_* registered, valid after edge R (1-cycle latency).
- Write-through bypass: if a commit to the same entry occurs at edge R, rd_* reflect the newly committed data. Net effect: a write accepted at E is readable by a read sampled at E+1.
- Unwritten entry: rd_valid = 0 and rd_opcode/rd_op_a/rd_op_b/rd_result/rd_div_err = 0. Outputs are forced to zero, memory is not read.
- entry_count:
  - +1 when a commit targets a previously invalid entry.
  - unchanged on overwrite of a valid entry.
  - never exceeds DEPTH.
- clear_en at edge C:
  - all valid bits cleared, entry_count = 0;
  - a commit at the same edge C still lands: that entry is valid and entry_count = 1;
  - the stage-1 write continues normally (not cancelled);
  - a read at edge C observes the post-clear state.
- Two in-flight writes to the same pointer commit in order; the later one wins.
- Pointers wrap naturally at AW bits. No out-of-range check; DEPTH must be a power of two.

Test Plan:
- Reset check: hold reset_n = 0 for 2 cycles with load_en = 1 -> all outputs 0, pipe_busy = 0, entry_count = 0; read any entry -> rd_valid = 0.
- Single write: ADD a = -7, b = 3 to entry 5 at edge E; read 5 sampled at E+1 -> rd_result = -4 (64-bit sign-extended), rd_opcode = 3, rd_valid = 1, entry_count = 1.
- MULT and divide-by-zero:
  - MULT a = 0x7FFFFFFF, b = 2 -> rd_result = 0xFFFFFFFE (no truncation).
  - DIV a = 9, b = 0 -> rd_result = 0, rd_div_err = 1.
  - MOD a = -7, b = 3 -> rd_result = -1.
- Streaming: 32 consecutive writes to entries 0..31, then random readback of 32 entries -> every rd_* matches the scoreboard; entry_count = 32; rewriting entry 4 keeps count at 32.
- Clear collision: writes to entries 1 and 2 at edges E and E+1, clear_en at E+1 -> after E+2 only entries 1 and 2 are valid, entry_count = 2; all others read rd_valid = 0.
- Reset mid-pipeline: write at E, reset_n = 0 at E+1 -> the entry never becomes valid; entry_count = 0, pipe_busy = 0.

Source files
------------

// File: rtl/instr_register_alu.sv
// instr_register_alu
//   Instruction register with a 2-stage ALU write pipeline. Each accepted
//   write is captured in stage 1, its result is computed and committed to
//   the entry array on the following edge, and a per-entry valid bit and
//   an occupancy counter track which entries hold data.
//
// Ports
//   clk            single clock, rising edge
//   reset_n        synchronous active-low reset
//   load_en        write request (no back-pressure)
//   clear_en       invalidate all entries
//   operand_a/b    signed operands, OP_W bits
//   opcode         ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
//   write_pointer  target entry of the write
//   read_pointer   entry to read (registered readout, 1-cycle latency)
//   rd_*           stored opcode/operands/result/div_err, rd_valid
//   entry_count    number of valid entries, 0..DEPTH
//   pipe_busy      a write is in stage 1 or stage 2
module instr_register_alu #(
  parameter  int OP_W  = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int RES_W = 2 * OP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic             clear_en,
  input  logic [OP_W-1:0]  operand_a,
  input  logic [OP_W-1:0]  operand_b,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    write_pointer,
  input  logic [AW-1:0]    read_pointer,
  output logic [2:0]       rd_opcode,
  output logic [OP_W-1:0]  rd_op_a,
  output logic [OP_W-1:0]  rd_op_b,
  output logic [RES_W-1:0] rd_result,
  output logic             rd_valid,
  output logic             rd_div_err,
  output logic [AW:0]      entry_count,
  output logic             pipe_busy
);

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] result;
    logic             div_err;
  } entry_t;

  // Stage 1 registers
  logic            s1_vld;
  logic            s2_vld;
  logic [2:0]      s1_op;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;
  logic [AW-1:0]   s1_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ptr <= '0;
    end else begin
      s1_vld <= load_en;
      // s2_vld only marks the commit edge so pipe_busy covers both stages
      s2_vld <= s1_vld;
      if (load_en) begin
        s1_op  <= opcode;
        s1_a   <= operand_a;
        s1_b   <= operand_b;
        s1_ptr <= write_pointer;
      end
    end
  end

  // ALU: operands are widened first so ADD/SUB/MULT and MIN/-1 cannot overflow
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] alu_res;
  logic                    alu_err;

  assign a_ext = {{OP_W{s1_a[OP_W-1]}}, s1_a};
  assign b_ext = {{OP_W{s1_b[OP_W-1]}}, s1_b};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (s1_op)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = a_ext;
      OP_PASSB: alu_res = b_ext;
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_SUB:   alu_res = a_ext - b_ext;
      OP_MULT:  alu_res = a_ext * b_ext;
      OP_DIV: begin
        if (s1_b == '0) alu_err = 1'b1;
        else            alu_res = a_ext / b_ext;
      end
      OP_MOD: begin
        if (s1_b == '0) alu_err = 1'b1;
        else            alu_res = a_ext % b_ext;
      end
      default:  alu_res = '0;
    endcase
  end

  entry_t commit_ent;
  assign commit_ent = {s1_op, s1_a, s1_b, alu_res, alu_err};

  // Entry storage; contents are qualified by the valid bits, so no reset
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset_n && s1_vld) mem[s1_ptr] <= commit_ent;
  end

  // Valid bits and occupancy: clear first, then the same-edge commit lands
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  always_comb begin
    valid_nxt = clear_en ? '0 : valid;
    count_nxt = clear_en ? '0 : count;
    if (s1_vld) begin
      if (!valid_nxt[s1_ptr]) count_nxt = count_nxt + (AW+1)'(1);
      valid_nxt[s1_ptr] = 1'b1;
    end
  end

  // Read source: bypass the commit of this edge, zero for invalid entries
  entry_t rd_src;

  always_comb begin
    rd_src = '0;
    if (valid_nxt[read_pointer]) begin
      if (s1_vld && (s1_ptr == read_pointer)) rd_src = commit_ent;
      else                                    rd_src = mem[read_pointer];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid      <= '0;
      count      <= '0;
      rd_opcode  <= '0;
      rd_op_a    <= '0;
      rd_op_b    <= '0;
      rd_result  <= '0;
      rd_div_err <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      valid      <= valid_nxt;
      count      <= count_nxt;
      rd_opcode  <= rd_src.opcode;
      rd_op_a    <= rd_src.op_a;
      rd_op_b    <= rd_src.op_b;
      rd_result  <= rd_src.result;
      rd_div_err <= rd_src.div_err;
      rd_valid   <= valid_nxt[read_pointer];
    end
  end

  assign entry_count = count;
  assign pipe_busy   = s1_vld | s2_vld;

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed testbench for instr_register_alu (default parameters).
module tb_instr_register_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic        clear_en;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  opcode;
  logic [4:0]  write_pointer;
  logic [4:0]  read_pointer;
  logic [2:0]  rd_opcode;
  logic [31:0] rd_op_a;
  logic [31:0] rd_op_b;
  logic [63:0] rd_result;
  logic        rd_valid;
  logic        rd_div_err;
  logic [5:0]  entry_count;
  logic        pipe_busy;

  int n_chk  = 0;
  int n_fail = 0;

  int     sb_op [32];
  int     sb_a  [32];
  int     sb_b  [32];
  longint sb_res[32];
  logic   sb_err[32];

  always #5 clk = ~clk;

  instr_register_alu dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_en      (load_en),
    .clear_en     (clear_en),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .opcode       (opcode),
    .write_pointer(write_pointer),
    .read_pointer (read_pointer),
    .rd_opcode    (rd_opcode),
    .rd_op_a      (rd_op_a),
    .rd_op_b      (rd_op_b),
    .rd_result    (rd_result),
    .rd_valid     (rd_valid),
    .rd_div_err   (rd_div_err),
    .entry_count  (entry_count),
    .pipe_busy    (pipe_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int op, input int a, input int b,
                        input longint res, input logic err);
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  eo;
    ea = a;
    eb = b;
    eo = op[2:0];
    chk({tag, ".valid"},  {63'd0, rd_valid}, 64'd1);
    chk({tag, ".opcode"}, {61'd0, rd_opcode}, {61'd0, eo});
    chk({tag, ".op_a"},   {32'd0, rd_op_a}, {32'd0, ea});
    chk({tag, ".op_b"},   {32'd0, rd_op_b}, {32'd0, eb});
    chk({tag, ".result"}, rd_result, res);
    chk({tag, ".div_err"}, {63'd0, rd_div_err}, {63'd0, err});
  endtask

  task automatic set_wr(input int op, input int a, input int b, input int p);
    load_en       = 1'b1;
    opcode        = op[2:0];
    operand_a     = a;
    operand_b     = b;
    write_pointer = p[4:0];
  endtask

  // write at edge E, read the same entry sampled at E+1
  task automatic wr_rd(input int op, input int a, input int b, input int p);
    set_wr(op, a, b, p);
    tick();
    load_en      = 1'b0;
    read_pointer = p[4:0];
    tick();
  endtask

  function automatic longint model(input int op, input int a, input int b);
    longint la = a;
    longint lb = b;
    case (op)
      1: return la;
      2: return lb;
      3: return la + lb;
      4: return la - lb;
      5: return la * lb;
      6: return (lb == 0) ? 64'sd0 : la / lb;
      7: return (lb == 0) ? 64'sd0 : la % lb;
      default: return 0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    load_en       = 1'b1;
    clear_en      = 1'b0;
    opcode        = 3'd3;
    operand_a     = 32'd1;
    operand_b     = 32'd1;
    write_pointer = 5'd0;
    read_pointer  = 5'd0;

    // reset held two cycles with load_en active
    tick();
    tick();
    chk("rst.rd_valid",   {63'd0, rd_valid}, 64'd0);
    chk("rst.rd_result",  rd_result, 64'd0);
    chk("rst.rd_opcode",  {61'd0, rd_opcode}, 64'd0);
    chk("rst.rd_op_a",    {32'd0, rd_op_a}, 64'd0);
    chk("rst.rd_div_err", {63'd0, rd_div_err}, 64'd0);
    chk("rst.count",      {58'd0, entry_count}, 64'd0);
    chk("rst.pipe_busy",  {63'd0, pipe_busy}, 64'd0);
    reset_n = 1'b1;
    load_en = 1'b0;
    tick();
    chk("post_rst.rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("post_rst.count",    {58'd0, entry_count}, 64'd0);

    // single ADD -7 + 3 into entry 5
    set_wr(3, -7, 3, 5);
    tick();
    chk("add.busy_s1", {63'd0, pipe_busy}, 64'd1);
    load_en      = 1'b0;
    read_pointer = 5'd5;
    tick();
    chk_rd("add", 3, -7, 3, -64'sd4, 1'b0);
    chk("add.count",   {58'd0, entry_count}, 64'd1);
    chk("add.busy_s2", {63'd0, pipe_busy}, 64'd1);
    tick();
    chk("add.busy_idle", {63'd0, pipe_busy}, 64'd0);

    wr_rd(5, 32'h7FFF_FFFF, 2, 6);
    chk_rd("mult", 5, 32'h7FFF_FFFF, 2, 64'h0000_0000_FFFF_FFFE, 1'b0);
    wr_rd(6, 9, 0, 7);
    chk_rd("div0", 6, 9, 0, 64'd0, 1'b1);
    wr_rd(7, -7, 3, 8);
    chk_rd("mod", 7, -7, 3, -64'sd1, 1'b0);
    wr_rd(6, -7, 2, 9);
    chk_rd("div", 6, -7, 2, -64'sd3, 1'b0);
    wr_rd(4, 32'h8000_0000, 1, 10);
    chk_rd("sub_min", 4, 32'h8000_0000, 1, -64'sd2147483649, 1'b0);
    chk("small.count", {58'd0, entry_count}, 64'd6);

    // back-to-back stream into all 32 entries
    for (int i = 0; i < 32; i++) begin
      sb_op[i]  = i % 8;
      sb_a[i]   = i * 123457 - 2000000;
      sb_b[i]   = (i % 5) - 2;
      sb_res[i] = model(sb_op[i], sb_a[i], sb_b[i]);
      sb_err[i] = ((sb_op[i] == 6) || (sb_op[i] == 7)) && (sb_b[i] == 0);
      set_wr(sb_op[i], sb_a[i], sb_b[i], i);
      tick();
    end
    load_en = 1'b0;
    tick();
    tick();
    chk("stream.count", {58'd0, entry_count}, 64'd32);
    chk("stream.busy",  {63'd0, pipe_busy}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      int p;
      p = (i * 13 + 7) % 32;
      read_pointer = p[4:0];
      tick();
      chk_rd($sformatf("stream[%0d]", p), sb_op[p], sb_a[p], sb_b[p], sb_res[p], sb_err[p]);
    end

    // overwrite of a valid entry keeps the count
    wr_rd(4, 100, 30, 4);
    chk_rd("rewrite4", 4, 100, 30, 64'd70, 1'b0);
    chk("rewrite4.count", {58'd0, entry_count}, 64'd32);

    // two in-flight writes to one entry: later wins
    set_wr(3, 1, 1, 3);
    tick();
    set_wr(4, 10, 4, 3);
    tick();
    load_en      = 1'b0;
    read_pointer = 5'd3;
    tick();
    chk_rd("same_ptr", 4, 10, 4, 64'd6, 1'b0);

    // clear colliding with a commit
    set_wr(3, 5, 6, 1);
    tick();
    set_wr(2, 0, -9, 2);
    clear_en     = 1'b1;
    read_pointer = 5'd1;
    tick();
    clear_en = 1'b0;
    load_en  = 1'b0;
    chk("clr.count_c", {58'd0, entry_count}, 64'd1);
    chk_rd("clr.e1", 3, 5, 6, 64'd11, 1'b0);
    read_pointer = 5'd2;
    tick();
    chk("clr.count", {58'd0, entry_count}, 64'd2);
    chk_rd("clr.e2", 2, 0, -9, -64'sd9, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic ev;
      ev = (i == 1) || (i == 2);
      read_pointer = i[4:0];
      tick();
      chk($sformatf("clr.valid[%0d]", i), {63'd0, rd_valid}, {63'd0, ev});
      if (!ev) begin
        chk($sformatf("clr.result[%0d]", i), rd_result, 64'd0);
        chk($sformatf("clr.opcode[%0d]", i), {61'd0, rd_opcode}, 64'd0);
      end
    end

    // reset while a write is in stage 1
    set_wr(3, 1, 2, 10);
    tick();
    load_en = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("midrst.busy",  {63'd0, pipe_busy}, 64'd0);
    chk("midrst.count", {58'd0, entry_count}, 64'd0);
    reset_n      = 1'b1;
    read_pointer = 5'd10;
    tick();
    chk("midrst.rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("midrst.count2",   {58'd0, entry_count}, 64'd0);
    chk("midrst.busy2",    {63'd0, pipe_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
